digit_render_sched: RTL

Sequencer and two-way arbiter for the single-digit glyph renderer. Two requesters (e.g. score and timer overlays) each submit a packed 4-digit BCD value plus screen position. The block grants one requester at a time and walks its digits most-significant first. For each digit it loads the renderer's glyph address and position, then enables the renderer for exactly one glyph's worth of cycles. It sits between the game-logic requesters and the renderer, whose frame-buffer write port it thereby time-shares.

---
 rtl/digit_render_sched.sv | 137 +++++++++++++
 1 files changed

// File: rtl/digit_render_sched.sv
// Two-way round-robin arbiter and digit sequencer for the single-digit glyph renderer.
// Walks a granted packed-BCD value most-significant first, one LOAD plus one RUN window per digit.
module digit_render_sched #(
    parameter int NDIG        = 4,
    parameter int DIG_W       = 12,
    parameter int GLYPH_WORDS = 216,
    parameter int CYC_PER_DIG = 864
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [4*NDIG-1:0] bcd0,
    input  logic [4*NDIG-1:0] bcd1,
    input  logic [9:0]        top0,
    input  logic [9:0]        top1,
    input  logic [9:0]        left0,
    input  logic [9:0]        left1,
    output logic [1:0]        ack,
    output logic [1:0]        done,
    output logic              busy,
    output logic [11:0]       dig_addr,
    output logic [9:0]        dig_top,
    output logic [9:0]        dig_left,
    output logic              dig_en
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW = (CYC_PER_DIG > 1) ? $clog2(CYC_PER_DIG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CYC_PER_DIG - 1);
    localparam logic [9:0]    X_STEP   = 10'(DIG_W);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t            state;
    logic              ptr;
    logic              owner;
    logic [IW-1:0]     idx;
    logic [CW-1:0]     cnt;
    logic [4*NDIG-1:0] pend;
    logic [3:0]        cur_dig;

    logic              win;
    logic              adv;
    logic [4*NDIG-1:0] sel_bcd;
    logic [9:0]        sel_top;
    logic [9:0]        sel_left;

    function automatic logic [11:0] glyph_base(input logic [3:0] d);
        return 12'(d) * 12'(GLYPH_WORDS);
    endfunction

    // A sole requester wins outright; a tie goes to the round-robin pointer.
    always_comb begin
        win      = (req == 2'b11) ? ptr : req[1];
        sel_bcd  = win ? bcd1  : bcd0;
        sel_top  = win ? top1  : top0;
        sel_left = win ? left1 : left0;
        adv      = ((state == LOAD) && (cur_dig > 4'd9)) ||
                   ((state == RUN)  && (cnt == CNT_LAST));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            owner    <= 1'b0;
            idx      <= '0;
            cnt      <= '0;
            pend     <= '0;
            cur_dig  <= '0;
            ack      <= '0;
            done     <= '0;
            busy     <= 1'b0;
            dig_addr <= '0;
            dig_top  <= '0;
            dig_left <= '0;
            dig_en   <= 1'b0;
        end else begin
            ack  <= '0;
            done <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner    <= win;
                        ptr      <= ~win;
                        ack      <= win ? 2'b10 : 2'b01;
                        busy     <= 1'b1;
                        idx      <= '0;
                        cur_dig  <= sel_bcd[4*NDIG-1 -: 4];
                        pend     <= {sel_bcd[4*NDIG-5:0], 4'h0};
                        dig_addr <= glyph_base(sel_bcd[4*NDIG-1 -: 4]);
                        dig_top  <= sel_top;
                        dig_left <= sel_left;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (cur_dig <= 4'd9) begin
                        dig_en <= 1'b1;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == CNT_LAST) begin
                        dig_en <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Blank digits and finished RUN windows both step to the next digit or finish the job.
            if (adv) begin
                if (idx == LAST_IDX) begin
                    done  <= owner ? 2'b10 : 2'b01;
                    state <= DONE;
                end else begin
                    idx      <= idx + IW'(1);
                    cur_dig  <= pend[4*NDIG-1 -: 4];
                    pend     <= {pend[4*NDIG-5:0], 4'h0};
                    dig_addr <= glyph_base(pend[4*NDIG-1 -: 4]);
                    dig_left <= dig_left + X_STEP;
                    state    <= LOAD;
                end
            end
        end
    end

endmodule
